// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter: funct3 codes, FSM states and
// the funct3 support check used to sanitise requests.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ADD_F3  = 3'b000;
  localparam logic [2:0] SLL_F3  = 3'b001;
  localparam logic [2:0] SLT_F3  = 3'b010;
  localparam logic [2:0] SLTU_F3 = 3'b011;
  localparam logic [2:0] XOR_F3  = 3'b100;
  localparam logic [2:0] SR_F3   = 3'b101;
  localparam logic [2:0] OR_F3   = 3'b110;
  localparam logic [2:0] AND_F3  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // The shared alu only implements add/or/and/sll/srl.
  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == ADD_F3) || (f3 == OR_F3) || (f3 == AND_F3) ||
           (f3 == SLL_F3) || (f3 == SR_F3);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels plus the alu-facing bus of the arbiter.
// slave = arbiter side, master = requesters/consumer/alu side.
interface alu_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) ();
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [XLEN-1:0]  req0_r1;
  logic [XLEN-1:0]  req0_r2;
  logic [2:0]       req0_funct3;
  logic [XLEN-1:0]  req1_r1;
  logic [XLEN-1:0]  req1_r2;
  logic [2:0]       req1_funct3;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [XLEN-1:0]  rsp_data;
  logic             rsp_zero;
  logic             rsp_err;
  logic [XLEN-1:0]  alu_r1;
  logic [XLEN-1:0]  alu_r2;
  logic [2:0]       alu_funct3;
  logic [XLEN-1:0]  alu_out;
  logic             alu_zero;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  req_valid, req0_r1, req0_r2, req0_funct3,
           req1_r1, req1_r2, req1_funct3, rsp_ready, alu_out, alu_zero,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
           alu_r1, alu_r2, alu_funct3, busy, op_count
  );

  modport master (
    output req_valid, req0_r1, req0_r2, req0_funct3,
           req1_r1, req1_r2, req1_funct3, rsp_ready, alu_out, alu_zero,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
           alu_r1, alu_r2, alu_funct3, busy, op_count
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational alu between the execute stage (req0) and
// the branch/address unit (req1); one operation in flight, tagged response.
module alu_arbiter #(
  parameter int XLEN  = alu_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  import alu_pkg::arb_state_t;
  import alu_pkg::IDLE;
  import alu_pkg::EXEC;
  import alu_pkg::RESP;
  import alu_pkg::ADD_F3;
  import alu_pkg::SLL_F3;
  import alu_pkg::SR_F3;
  import alu_pkg::f3_supported;

  localparam int SHAMT_W = $clog2(XLEN);

  arb_state_t       state_reg;
  arb_state_t       state_next;
  logic             last_grant_reg;
  logic [1:0]       gnt;
  logic             accept;
  logic             sel_id;
  logic [XLEN-1:0]  sel_r1;
  logic [XLEN-1:0]  sel_r2;
  logic [2:0]       sel_f3;
  logic [XLEN-1:0]  san_r1;
  logic [XLEN-1:0]  san_r2;
  logic [2:0]       san_f3;
  logic             san_err;
  logic [XLEN-1:0]  op_r1_reg;
  logic [XLEN-1:0]  op_r2_reg;
  logic [2:0]       op_f3_reg;
  logic             op_id_reg;
  logic             op_err_reg;
  logic [XLEN-1:0]  rsp_data_reg;
  logic             rsp_zero_reg;
  logic [CNT_W-1:0] op_count_reg;

  rr_arb2 u_rr_arb2 (
    .req  (bus.req_valid),
    .last (last_grant_reg),
    .gnt  (gnt)
  );

  // Ready is a function of valid and state only, never of the response side.
  assign bus.req_ready = (state_reg == IDLE) ? gnt : 2'b00;
  assign accept        = |(bus.req_valid & bus.req_ready);

  assign sel_id = gnt[1];
  assign sel_r1 = sel_id ? bus.req1_r1     : bus.req0_r1;
  assign sel_r2 = sel_id ? bus.req1_r2     : bus.req0_r2;
  assign sel_f3 = sel_id ? bus.req1_funct3 : bus.req0_funct3;

  // Unsupported codes become add 0+0 so the alu yields a clean zero result.
  always_comb begin
    san_err = !f3_supported(sel_f3);
    san_f3  = sel_f3;
    san_r1  = sel_r1;
    san_r2  = sel_r2;
    if (san_err) begin
      san_f3 = ADD_F3;
      san_r1 = '0;
      san_r2 = '0;
    end else if ((sel_f3 == SLL_F3) || (sel_f3 == SR_F3)) begin
      san_r2 = {{(XLEN-SHAMT_W){1'b0}}, sel_r2[SHAMT_W-1:0]};
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
      op_r1_reg      <= '0;
      op_r2_reg      <= '0;
      op_f3_reg      <= '0;
      op_id_reg      <= 1'b0;
      op_err_reg     <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_zero_reg   <= 1'b0;
    end else begin
      if (accept) begin
        last_grant_reg <= sel_id;
        op_r1_reg      <= san_r1;
        op_r2_reg      <= san_r2;
        op_f3_reg      <= san_f3;
        op_id_reg      <= sel_id;
        op_err_reg     <= san_err;
      end
      if (state_reg == EXEC) begin
        rsp_data_reg <= op_err_reg ? '0 : bus.alu_out;
        rsp_zero_reg <= op_err_reg | bus.alu_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_reg <= '0;
    end else if ((state_reg == RESP) && bus.rsp_ready) begin
      op_count_reg <= op_count_reg + CNT_W'(1);
    end
  end

  assign bus.alu_r1     = op_r1_reg;
  assign bus.alu_r2     = op_r2_reg;
  assign bus.alu_funct3 = op_f3_reg;
  assign bus.rsp_valid  = (state_reg == RESP);
  assign bus.rsp_id     = op_id_reg;
  assign bus.rsp_data   = rsp_data_reg;
  assign bus.rsp_zero   = rsp_zero_reg;
  assign bus.rsp_err    = op_err_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.op_count   = op_count_reg;

endmodule
